bus_mem_responder: RTL and testbench
====================================

Name: bus_mem_responder

Overview:
- Memory-side responder for the CPU's shared 8-bit external bus: addr_bus, read_en, write_en, memory_select and a bidirectional data_bus.
- Decodes each bus request to internal RAM (memory_select=1) or program ROM (memory_select=0). Returns read data with a configurable wait-state latency and signals completion on ready.
- ROM contents are loaded via a side-band load port before the CPU leaves reset.

Parameters:
- RAM_DEPTH, 256, RAM bytes; valid addresses 0..RAM_DEPTH-1
- ROM_DEPTH, 4096, ROM bytes; valid addresses 0..ROM_DEPTH-1
- READ_LAT, 1, wait cycles between request sample and data drive (0..7)
- OOR_DATA, 8'hFF, read data returned for out-of-range addresses

Ports:
- clk  in  1  single system clock
- reset  in  1  asynchronous, active-high reset
- addr_bus  in  16  request address
- data_bus  inout  8  driven by this block only in DRIVE state, else high-Z
- read_en  in  1  read request, sampled at posedge
- write_en  in  1  write request, sampled at posedge
- memory_select  in  1  1=RAM, 0=ROM
- ready  out  1  one-cycle completion pulse
- bus_err  out  1  one-cycle error pulse
- rom_load_en  in  1  ROM load strobe
- rom_load_addr  in  16  ROM load address
- rom_load_data  in  8  ROM load byte

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high.
- Reset state:
  - FSM in IDLE; ready=0, bus_err=0, data_bus high-Z; latched addr/select cleared.
  - RAM/ROM contents are not cleared.
  - Reset asserted mid-transaction aborts it immediately (asynchronously): no ready, bus released at once.
- FSM states: IDLE, WAIT, DRIVE.
- IDLE, request sampled at a posedge:
  - read_en=1, write_en=0: latch addr_bus and memory_select; go to WAIT, or to DRIVE if READ_LAT=0; wait counter loaded with READ_LAT.
  - write_en=1, read_en=0, memory_select=1, address in range: RAM[addr] <= data_bus on that same edge; ready=1 for the next cycle; stay IDLE.
  - write_en=1, memory_select=0 (ROM): no store; bus_err=1 for the next cycle; stay IDLE.
  - read_en=1 and write_en=1 together: request ignored; bus_err pulse; stay IDLE.
- WAIT:
  - Counter decrements each cycle; when it reaches 1, go to DRIVE.
  - Requests arriving in WAIT are ignored (no queueing); each ignored request produces a bus_err pulse.
- DRIVE (exactly one cycle):
  - data_bus = read data registered on the edge entering DRIVE; ready=1.
  - Next state is IDLE; data_bus returns to high-Z.
  - A new request sampled on the DRIVE->IDLE edge is not accepted.
- Read latency: data and ready appear READ_LAT+1 cycles after the sample edge.
- Out of range (addr >= RAM_DEPTH or addr >= ROM_DEPTH for the selected space):
  - Read returns OOR_DATA with ready=1 and bus_err=1 in the same DRIVE cycle.
  - Write stores nothing and pulses bus_err only.
- ROM load:
  - rom_load_en at a posedge writes ROM[rom_load_addr] <= rom_load_data in any state.
  - Out-of-range load addresses are dropped silently.
  - Load and read capture to the same address on the same edge: the read returns the old byte.
- Address wrap: none. The full 16-bit address is compared against the depth; there is no aliasing.
- ready and bus_err are registered outputs; they are never both high except on an out-of-range read.

Optional Feature:
- Macro: ROM_BUS_WRITE_EN.
- Defined: a write with memory_select=0 and an in-range address stores data_bus into ROM[addr] and pulses ready with no bus_err. An out-of-range ROM write still pulses bus_err. A bus write and rom_load_en hitting the same edge: rom_load wins.
- Undefined: ROM writes over the bus are rejected with a bus_err pulse as described above; ROM changes only via the load port.

Test Plan:
- Load ROM[16'h0010]=8'hA5 via load port; READ_LAT=1; read addr 16'h0010, select=0 -> data_bus=8'hA5 with ready=1 exactly 2 cycles after sample; high-Z before and after.
- Write RAM[8'h30]=8'h5C (select=1) then read 8'h30 -> ready pulse after write; read returns 8'h5C; bus_err stays 0 throughout.
- Read RAM addr 16'h0100 (RAM_DEPTH=256) -> data_bus=8'hFF; ready=1 and bus_err=1 in the same cycle.
- read_en and write_en asserted together -> bus_err pulse next cycle, no ready, RAM unchanged. Then a second read issued during WAIT -> ignored with a bus_err pulse; the first read still completes.
- Assert reset during WAIT of a read to ROM 16'h0010 -> data_bus high-Z immediately, no ready; after release the FSM is IDLE and a new read returns 8'hA5.
- ROM write 8'h77 to 16'h0020 over the bus: without ROM_BUS_WRITE_EN -> bus_err and readback is the old value; with it defined -> ready and readback 8'h77.

Source files
------------

// File: rtl/bus_mem_responder.sv
// Memory-side responder for the shared 8-bit CPU bus: RAM, program ROM, wait states.
// Define ROM_BUS_WRITE_EN to let bus writes with memory_select=0 store into ROM.
module bus_mem_responder #(
  parameter int         RAM_DEPTH = 256,
  parameter int         ROM_DEPTH = 4096,
  parameter int         READ_LAT  = 1,
  parameter logic [7:0] OOR_DATA  = 8'hFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addr_bus,
  inout  logic [7:0]  data_bus,
  input  logic        read_en,
  input  logic        write_en,
  input  logic        memory_select,
  output logic        ready,
  output logic        bus_err,
  input  logic        rom_load_en,
  input  logic [15:0] rom_load_addr,
  input  logic [7:0]  rom_load_data
);

  localparam int          RAM_AW  = $clog2(RAM_DEPTH);
  localparam int          ROM_AW  = $clog2(ROM_DEPTH);
  localparam logic [16:0] RAM_LIM = 17'(RAM_DEPTH);
  localparam logic [16:0] ROM_LIM = 17'(ROM_DEPTH);
  localparam logic [2:0]  LAT     = 3'(READ_LAT);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRIVE} state_t;

  state_t      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic        sel_q, sel_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        ready_q, ready_d;
  logic        err_q, err_d;
  logic        pend_q, pend_d;

  logic [7:0]  ram_q [RAM_DEPTH];
  logic [7:0]  rom_q [ROM_DEPTH];

  logic [15:0] rd_addr;
  logic        rd_sel, rd_ok, wr_ok, ld_ok, go_drive;
  logic [7:0]  rd_byte;
  logic        ram_we, rom_bus_we;

  function automatic logic hit(input logic [15:0] a, input logic sel);
    return sel ? ({1'b0, a} < RAM_LIM) : ({1'b0, a} < ROM_LIM);
  endfunction

  always_comb begin
    rd_addr = (state_q == S_IDLE) ? addr_bus : addr_q;
    rd_sel  = (state_q == S_IDLE) ? memory_select : sel_q;
    rd_ok   = hit(rd_addr, rd_sel);
    wr_ok   = hit(addr_bus, memory_select);
    ld_ok   = {1'b0, rom_load_addr} < ROM_LIM;
    rd_byte = rd_sel ? ram_q[rd_addr[RAM_AW-1:0]]
                     : rom_q[rd_addr[ROM_AW-1:0]];
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    sel_d      = sel_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    ready_d    = 1'b0;
    err_d      = 1'b0;
    pend_d     = 1'b0;
    ram_we     = 1'b0;
    rom_bus_we = 1'b0;
    go_drive   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (read_en && write_en) begin
          err_d = 1'b1;
        end else if (read_en) begin
          addr_d = addr_bus;
          sel_d  = memory_select;
          cnt_d  = LAT;
          if (LAT == 3'd0) go_drive = 1'b1;
          else             state_d  = S_WAIT;
        end else if (write_en) begin
          if (!wr_ok) begin
            err_d = 1'b1;
          end else if (memory_select) begin
            ram_we  = 1'b1;
            ready_d = 1'b1;
          end else begin
`ifdef ROM_BUS_WRITE_EN
            rom_bus_we = 1'b1;
            ready_d    = 1'b1;
`else
            err_d = 1'b1;
`endif
          end
        end
      end
      S_WAIT: begin
        if (cnt_q <= 3'd1) go_drive = 1'b1;
        else               cnt_d    = cnt_q - 3'd1;
        // An error on the edge into DRIVE is deferred one cycle so it never overlaps ready
        if (read_en || write_en) begin
          if (go_drive) pend_d = 1'b1;
          else          err_d  = 1'b1;
        end
      end
      S_DRIVE: begin
        state_d = S_IDLE;
        err_d   = pend_q;
      end
      default: state_d = S_IDLE;
    endcase
    if (go_drive) begin
      state_d = S_DRIVE;
      rdata_d = rd_ok ? rd_byte : OOR_DATA;
      ready_d = 1'b1;
      err_d   = !rd_ok;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      sel_q   <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      pend_q  <= pend_d;
    end
  end

  // Storage is never cleared; ROM loads are honoured even while reset is held
  always_ff @(posedge clk) begin
    if (ram_we && !reset) ram_q[addr_bus[RAM_AW-1:0]] <= data_bus;
    if (rom_load_en && ld_ok)
      rom_q[rom_load_addr[ROM_AW-1:0]] <= rom_load_data;
    else if (rom_bus_we && !reset)
      rom_q[addr_bus[ROM_AW-1:0]] <= data_bus;
  end

  assign data_bus = (state_q == S_DRIVE) ? rdata_q : 8'hzz;
  assign ready    = ready_q;
  assign bus_err  = err_q;

endmodule

// File: tb/tb_bus_mem_responder.sv
// Directed bench for bus_mem_responder (default parameters, READ_LAT=1).
// Released bus reads as 8'h00 through the tri0 net.
module tb_bus_mem_responder;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] addr_bus;
  logic        read_en, write_en, memory_select;
  logic        ready, bus_err;
  logic        rom_load_en;
  logic [15:0] rom_load_addr;
  logic [7:0]  rom_load_data;
  logic        tb_oe;
  logic [7:0]  tb_dat;
  tri0  [7:0]  data_bus;
  int          checks = 0;
  int          fails = 0;

  assign data_bus = tb_oe ? tb_dat : 8'hzz;
  always #5 clk = ~clk;

  bus_mem_responder dut (
    .clk(clk), .reset(reset), .addr_bus(addr_bus), .data_bus(data_bus),
    .read_en(read_en), .write_en(write_en), .memory_select(memory_select),
    .ready(ready), .bus_err(bus_err), .rom_load_en(rom_load_en),
    .rom_load_addr(rom_load_addr), .rom_load_data(rom_load_data)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_read(input logic [15:0] a, input logic sel);
    addr_bus = a; memory_select = sel; read_en = 1'b1;
    tick();
    read_en = 1'b0;
  endtask

  task automatic do_write(input logic [15:0] a, input logic sel,
                          input logic [7:0] d);
    addr_bus = a; memory_select = sel; tb_dat = d;
    tb_oe = 1'b1; write_en = 1'b1;
    tick();
    write_en = 1'b0; tb_oe = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; addr_bus = '0; read_en = 0; write_en = 0;
    memory_select = 0; tb_oe = 0; tb_dat = '0;
    rom_load_en = 1'b1;
    rom_load_addr = 16'h0010; rom_load_data = 8'hA5; tick();
    rom_load_addr = 16'h0020; rom_load_data = 8'h3C; tick();
    rom_load_addr = 16'h0040; rom_load_data = 8'h12; tick();
    rom_load_en = 1'b0;
    checks++; if (ready !== 1'b0) begin fails++; $display("FAIL reset_ready got %b want 0", ready); end
    checks++; if (bus_err !== 1'b0) begin fails++; $display("FAIL reset_err got %b want 0", bus_err); end
    checks++; if (data_bus !== 8'h00) begin fails++; $display("FAIL reset_bus got %h want 00", data_bus); end
    reset = 1'b0;
    tick();
    checks++; if (ready !== 1'b0 || bus_err !== 1'b0) begin fails++; $display("FAIL post_reset got rdy=%b err=%b want 0 0", ready, bus_err); end
  endtask

  task automatic test_rom_read;
    start_read(16'h0010, 1'b0);
    checks++; if (ready !== 1'b0 || data_bus !== 8'h00) begin fails++; $display("FAIL rom_wait got rdy=%b bus=%h want 0 00", ready, data_bus); end
    tick();
    checks++; if (data_bus !== 8'hA5) begin fails++; $display("FAIL rom_data got %h want a5", data_bus); end
    checks++; if (ready !== 1'b1 || bus_err !== 1'b0) begin fails++; $display("FAIL rom_ready got rdy=%b err=%b want 1 0", ready, bus_err); end
    tick();
    checks++; if (ready !== 1'b0 || data_bus !== 8'h00) begin fails++; $display("FAIL rom_release got rdy=%b bus=%h want 0 00", ready, data_bus); end
  endtask

  task automatic test_ram_write_read;
    do_write(16'h0030, 1'b1, 8'h5C);
    checks++; if (ready !== 1'b1 || bus_err !== 1'b0) begin fails++; $display("FAIL ram_wr_ack got rdy=%b err=%b want 1 0", ready, bus_err); end
    tick();
    checks++; if (ready !== 1'b0) begin fails++; $display("FAIL ram_wr_pulse got %b want 0", ready); end
    start_read(16'h0030, 1'b1);
    tick();
    checks++; if (data_bus !== 8'h5C || ready !== 1'b1 || bus_err !== 1'b0) begin fails++; $display("FAIL ram_rd got bus=%h rdy=%b err=%b want 5c 1 0", data_bus, ready, bus_err); end
    tick();
  endtask

  task automatic test_oor;
    start_read(16'h0100, 1'b1);
    tick();
    checks++; if (data_bus !== 8'hFF || ready !== 1'b1 || bus_err !== 1'b1) begin fails++; $display("FAIL oor_rd got bus=%h rdy=%b err=%b want ff 1 1", data_bus, ready, bus_err); end
    tick();
    checks++; if (ready !== 1'b0 || bus_err !== 1'b0) begin fails++; $display("FAIL oor_end got rdy=%b err=%b want 0 0", ready, bus_err); end
    do_write(16'h0130, 1'b1, 8'hEE);
    checks++; if (ready !== 1'b0 || bus_err !== 1'b1) begin fails++; $display("FAIL oor_wr got rdy=%b err=%b want 0 1", ready, bus_err); end
    tick();
    start_read(16'h0030, 1'b1);
    tick();
    checks++; if (data_bus !== 8'h5C) begin fails++; $display("FAIL oor_wr_alias got %h want 5c", data_bus); end
    tick();
  endtask

  task automatic test_conflict_and_wait;
    addr_bus = 16'h0030; memory_select = 1'b1; tb_dat = 8'h11; tb_oe = 1'b1;
    read_en = 1'b1; write_en = 1'b1;
    tick();
    read_en = 1'b0; write_en = 1'b0; tb_oe = 1'b0;
    checks++; if (ready !== 1'b0 || bus_err !== 1'b1) begin fails++; $display("FAIL conflict got rdy=%b err=%b want 0 1", ready, bus_err); end
    tick();
    start_read(16'h0030, 1'b1);
    tick();
    checks++; if (data_bus !== 8'h5C) begin fails++; $display("FAIL conflict_ram got %h want 5c", data_bus); end
    tick();
    start_read(16'h0010, 1'b0);
    addr_bus = 16'h0030; memory_select = 1'b1; read_en = 1'b1;
    tick();
    read_en = 1'b0;
    checks++; if (data_bus !== 8'hA5 || ready !== 1'b1 || bus_err !== 1'b0) begin fails++; $display("FAIL wait_first got bus=%h rdy=%b err=%b want a5 1 0", data_bus, ready, bus_err); end
    tick();
    checks++; if (bus_err !== 1'b1 || ready !== 1'b0) begin fails++; $display("FAIL wait_ignored got err=%b rdy=%b want 1 0", bus_err, ready); end
    tick();
    checks++; if (bus_err !== 1'b0 || ready !== 1'b0 || data_bus !== 8'h00) begin fails++; $display("FAIL wait_idle got err=%b rdy=%b bus=%h want 0 0 00", bus_err, ready, data_bus); end
  endtask

  task automatic test_reset_mid;
    start_read(16'h0010, 1'b0);
    #2 reset = 1'b1;
    #1;
    checks++; if (ready !== 1'b0 || data_bus !== 8'h00) begin fails++; $display("FAIL rst_wait got rdy=%b bus=%h want 0 00", ready, data_bus); end
    tick(); tick();
    checks++; if (ready !== 1'b0 || data_bus !== 8'h00) begin fails++; $display("FAIL rst_hold got rdy=%b bus=%h want 0 00", ready, data_bus); end
    reset = 1'b0;
    tick();
    start_read(16'h0010, 1'b0);
    tick();
    checks++; if (data_bus !== 8'hA5 || ready !== 1'b1) begin fails++; $display("FAIL rst_drive got bus=%h rdy=%b want a5 1", data_bus, ready); end
    #2 reset = 1'b1;
    #1;
    checks++; if (ready !== 1'b0 || data_bus !== 8'h00) begin fails++; $display("FAIL rst_async got rdy=%b bus=%h want 0 00", ready, data_bus); end
    tick();
    reset = 1'b0;
    tick();
    start_read(16'h0010, 1'b0);
    tick();
    checks++; if (data_bus !== 8'hA5) begin fails++; $display("FAIL rst_after got %h want a5", data_bus); end
    tick();
  endtask

  task automatic test_rom_load;
    rom_load_en = 1'b1; rom_load_addr = 16'h1010; rom_load_data = 8'h99;
    tick();
    rom_load_en = 1'b0;
    start_read(16'h0010, 1'b0);
    tick();
    checks++; if (data_bus !== 8'hA5) begin fails++; $display("FAIL load_oor got %h want a5", data_bus); end
    tick();
    start_read(16'h0040, 1'b0);
    rom_load_en = 1'b1; rom_load_addr = 16'h0040; rom_load_data = 8'h34;
    tick();
    rom_load_en = 1'b0;
    checks++; if (data_bus !== 8'h12) begin fails++; $display("FAIL load_same_edge got %h want 12", data_bus); end
    tick();
    start_read(16'h0040, 1'b0);
    tick();
    checks++; if (data_bus !== 8'h34) begin fails++; $display("FAIL load_new got %h want 34", data_bus); end
    tick();
  endtask

  task automatic test_rom_bus_write;
    do_write(16'h0020, 1'b0, 8'h77);
`ifdef ROM_BUS_WRITE_EN
    checks++; if (ready !== 1'b1 || bus_err !== 1'b0) begin fails++; $display("FAIL rom_wr got rdy=%b err=%b want 1 0", ready, bus_err); end
`else
    checks++; if (ready !== 1'b0 || bus_err !== 1'b1) begin fails++; $display("FAIL rom_wr got rdy=%b err=%b want 0 1", ready, bus_err); end
`endif
    tick();
    start_read(16'h0020, 1'b0);
    tick();
`ifdef ROM_BUS_WRITE_EN
    checks++; if (data_bus !== 8'h77) begin fails++; $display("FAIL rom_wr_rd got %h want 77", data_bus); end
`else
    checks++; if (data_bus !== 8'h3C) begin fails++; $display("FAIL rom_wr_rd got %h want 3c", data_bus); end
`endif
    tick();
  endtask

  initial begin
    test_reset();
    test_rom_read();
    test_ram_write_read();
    test_oor();
    test_conflict_and_wait();
    test_reset_mid();
    test_rom_load();
    test_rom_bus_write();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end
endmodule
